mul_issue_ctrl: RTL and testbench

//  Shares one pipelined `multiply` unit (fixed latency, no stall, one op/cycle) between N_REQ pipeline requesters.
//  - Round-robin arbitration selects one request per cycle.
//  - Registers the operands into the multiplier and tracks each op's owner through the pipe with a tag shift register.
//  - Returns the product to the owning requester as a one-cycle response strobe.
//  - Sits in the EX stage between the issue logic and the shared multiplier; `flush` kills wrong-path ops.

---
 rtl/mul_ctrl_pkg.sv | 8 +
 rtl/mul_issue_ctrl_rr_arbiter.sv | 29 ++
 rtl/mul_issue_ctrl.sv | 64 ++++++
 tb/tb_mul_issue_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared defaults and tag types for the multiplier issue controller
package mul_ctrl_pkg;
  localparam int W_DEF = 32;
  localparam int N_REQ_DEF = 2;
  localparam int MUL_LAT_DEF = 2;
  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;
  typedef struct packed {logic vld; req_id_t id;} mul_tag_t;
endpackage

// File: rtl/mul_issue_ctrl_rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter (clk, rst, req[N] in, upd advances pointer past current winner, gnt[N] one-hot out)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] gnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, nxt;
  logic found;
  always_comb begin
    gnt = '0;
    nxt = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!found && j == (int'(ptr) + i) % N && req[j]) begin
          gnt[j] = 1'b1;
          nxt = PW'((j + 1) % N);
          found = 1'b1;
        end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (upd) ptr <= nxt;
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: shares one pipelined multiplier among N_REQ requesters (req_valid/ready/a/b in, flush, mul_a/b out, mul_c in, resp_valid/data out, busy)
module mul_issue_ctrl import mul_ctrl_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic               flush,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [W-1:0]       mul_c,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [W-1:0]       resp_data,
  output logic               busy
);
  localparam int IW = $clog2(N_REQ);
  typedef struct packed {logic vld; logic [IW-1:0] id;} tag_t;
  tag_t [MUL_LAT:0] tag;
  logic [N_REQ-1:0] gnt;
  logic acc, done;
  logic [IW-1:0] wid;
  logic [W-1:0] sel_a, sel_b;
  rr_arbiter #(.N(N_REQ)) u_arb (.clk, .rst, .req(req_valid), .upd(acc), .gnt);
  assign req_ready = (rst || flush) ? '0 : gnt;
  assign acc = |req_ready;
  // the last tag stage lines up with mul_c for its op; flush also kills that final stage
  assign done = tag[MUL_LAT].vld && !flush;
  always_comb begin
    wid = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) begin
        wid = IW'(i);
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
  end
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) busy = busy | tag[k].vld;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      resp_data <= '0;
      resp_valid <= '0;
      tag <= '0;
    end else begin
      if (acc) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      tag <= flush ? '0 : {tag[MUL_LAT-1:0], tag_t'{acc, wid}};
      resp_valid <= done ? N_REQ'(1) << tag[MUL_LAT].id : '0;
      if (done) resp_data <= mul_c;
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed scoreboard bench for mul_issue_ctrl with a behavioural pipelined multiplier
module tb_mul_issue_ctrl;
  localparam int W = 32;
  localparam int N = 2;
  localparam int L = 2;
  typedef struct {logic [N-1:0] oh; logic [W-1:0] d; int c;} exp_t;
  logic clk = 0, rst, flush;
  logic [N-1:0] req_valid, req_ready, resp_valid;
  logic [W-1:0] a0, b0, a1, b1, mul_a, mul_b, mul_c, resp_data;
  logic busy;
  logic [W-1:0] pipe [L];
  exp_t sb [$];
  int errs = 0, checks = 0, cyc_n = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;
  always_ff @(posedge clk) begin
    pipe[0] <= mul_a * mul_b;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_c = pipe[L-1];
  mul_issue_ctrl #(.W(W), .N_REQ(N), .MUL_LAT(L)) dut (
    .clk, .rst, .req_valid, .req_ready, .req_a({a1, a0}), .req_b({b1, b0}),
    .flush, .mul_a, .mul_b, .mul_c, .resp_valid, .resp_data, .busy);
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic set(input logic [N-1:0] v, input logic [W-1:0] xa0, xb0, xa1, xb1);
    req_valid = v; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
  endtask
  task automatic cyc(input logic [N-1:0] er, input string t);
    exp_t e;
    @(negedge clk);
    chk(t, req_ready, er);
    if (flush || rst) sb.delete();
    if (|req_ready) begin
      e.oh = req_ready;
      e.d = req_ready[1] ? a1 * b1 : a0 * b0;
      e.c = cyc_n + L + 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask
  task automatic drain(input string t);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(t, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if ((|resp_valid) === 1'b1) begin
      if (sb.size() == 0) chk("resp_spurious", resp_valid, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_valid", resp_valid, e.oh);
        chk("resp_data", resp_data, e.d);
        chk("resp_cycle", cyc_n, e.c);
      end
    end
  initial begin
    rst = 1; flush = 0;
    set(2'b01, 0, 0, 0, 0);
    cyc(2'b00, "rdy_in_rst");
    cyc(2'b00, "rdy_in_rst");
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    set(2'b01, 10, 10, 0, 0);
    cyc(2'b01, "rdy_single");
    set(2'b00, 0, 0, 0, 0);
    chk("busy_single", busy, 1);
    drain("drain_single");
    chk("single_data", resp_data, 100);
    chk("busy_idle", busy, 0);
    set(2'b10, 0, 0, 32'hFFFF_FFFF, 2);
    cyc(2'b10, "rdy_wrap1");
    set(2'b10, 0, 0, 32'h8000_0000, 2);
    cyc(2'b10, "rdy_wrap2");
    set(2'b00, 0, 0, 0, 0);
    drain("drain_wrap");
    set(2'b11, 7, 6, 3, 5);
    cyc(2'b01, "rdy_cont0");
    cyc(2'b10, "rdy_cont1");
    cyc(2'b01, "rdy_cont2");
    cyc(2'b10, "rdy_cont3");
    set(2'b00, 0, 0, 0, 0);
    drain("drain_cont");
    set(2'b01, 2, 3, 0, 0);
    cyc(2'b01, "rdy_fl0");
    set(2'b01, 4, 5, 0, 0);
    cyc(2'b01, "rdy_fl1");
    set(2'b01, 6, 7, 0, 0);
    cyc(2'b01, "rdy_fl2");
    flush = 1;
    set(2'b01, 8, 9, 0, 0);
    cyc(2'b00, "rdy_flush");
    flush = 0;
    set(2'b00, 0, 0, 0, 0);
    chk("busy_flush", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("flush_sb", sb.size(), 0);
    set(2'b10, 0, 0, 11, 11);
    cyc(2'b10, "rdy_pre_rst1");
    set(2'b01, 12, 12, 0, 0);
    cyc(2'b01, "rdy_pre_rst0");
    rst = 1;
    set(2'b00, 0, 0, 0, 0);
    cyc(2'b00, "rdy_mid_rst");
    rst = 0;
    chk("mrst_mul_a", mul_a, 0);
    chk("mrst_mul_b", mul_b, 0);
    chk("mrst_resp_data", resp_data, 0);
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_busy", busy, 0);
    set(2'b11, 5, 5, 6, 6);
    cyc(2'b01, "rdy_prio_after_rst");
    set(2'b00, 0, 0, 0, 0);
    drain("drain_rst");
    for (int i = 0; i < 5; i++) begin
      set(2'b10, 0, 0, 32'(i + 1), 32'(100 + i));
      cyc(2'b10, "rdy_req1_only");
    end
    set(2'b00, 0, 0, 0, 0);
    drain("drain_req1");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
